// File: rtl/nn_config_loader.sv
// -----------------------------------------------------------------------------
// nn_config_loader
//   Initiator side of the neuron weight/bias configuration bus. Consumes a
//   32-bit host word stream, decodes packet headers, and broadcasts weights and
//   biases to every neuron together with the target layer/neuron numbers.
//
//   Header word: [31] type (0 = weights, 1 = bias), [30] reserved,
//                [29:24] layer, [23:16] neuron, [15:0] weight count.
//
// Ports
//   clk               system clock
//   rst               synchronous, active-high reset
//   s_data            host stream word (header or payload)
//   s_valid           s_data valid
//   s_ready           word accepted this cycle (low only while rst is high)
//   weight_valid      one weight on weight_value this cycle
//   bias_valid        bias on bias_value this cycle
//   weight_value      weight word (holds while weight_valid is low)
//   bias_value        bias word (holds while bias_valid is low)
//   config_layer_num  target layer, zero-extended
//   config_neuron_num target neuron, zero-extended
//   pkt_done          one-cycle pulse when a packet has been fully consumed
//   err               sticky illegal-header flag, cleared only by rst
//   busy              FSM is not in IDLE
// -----------------------------------------------------------------------------
module nn_config_loader #(
  parameter int unsigned max_weight = 784,
  parameter int unsigned num_layers = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weight_valid,
  output logic        bias_valid,
  output logic [31:0] weight_value,
  output logic [31:0] bias_value,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        pkt_done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WEIGHTS,
    ST_BIAS,
    ST_DISCARD
  } state_t;

  // Registered state and outputs
  state_t      r_state;
  logic [15:0] r_remaining;
  logic        r_weight_valid;
  logic        r_bias_valid;
  logic [31:0] r_weight_value;
  logic [31:0] r_bias_value;
  logic [31:0] r_layer_num;
  logic [31:0] r_neuron_num;
  logic        r_pkt_done;
  logic        r_err;

  // Next-state values
  state_t      w_state_nxt;
  logic [15:0] w_remaining_nxt;
  logic        w_weight_valid_nxt;
  logic        w_bias_valid_nxt;
  logic [31:0] w_weight_value_nxt;
  logic [31:0] w_bias_value_nxt;
  logic [31:0] w_layer_num_nxt;
  logic [31:0] w_neuron_num_nxt;
  logic        w_pkt_done_nxt;
  logic        w_err_nxt;

  // Header decode (only meaningful when the current word is a header)
  logic        w_beat;
  logic        w_hdr_is_bias;
  logic [5:0]  w_hdr_layer;
  logic [7:0]  w_hdr_neuron;
  logic [15:0] w_hdr_count;
  logic        w_hdr_bad_layer;
  logic        w_hdr_oversize;
  logic [15:0] w_hdr_discard_len;

  // There is no backpressure: every cycle outside reset accepts a word.
  assign s_ready = ~rst;
  assign w_beat  = s_valid & s_ready;

  assign w_hdr_is_bias     = s_data[31];
  assign w_hdr_layer       = s_data[29:24];
  assign w_hdr_neuron      = s_data[23:16];
  assign w_hdr_count       = s_data[15:0];
  assign w_hdr_bad_layer   = ({26'd0, w_hdr_layer} >= 32'(num_layers));
  assign w_hdr_oversize    = ({16'd0, w_hdr_count} > 32'(max_weight));
  // A packet with an illegal layer still has to be drained: one word for a
  // bias packet, count words for a weight packet.
  assign w_hdr_discard_len = w_hdr_is_bias ? 16'd1 : w_hdr_count;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt        = r_state;
    w_remaining_nxt    = r_remaining;
    w_weight_valid_nxt = 1'b0;
    w_bias_valid_nxt   = 1'b0;
    w_weight_value_nxt = r_weight_value;
    w_bias_value_nxt   = r_bias_value;
    w_layer_num_nxt    = r_layer_num;
    w_neuron_num_nxt   = r_neuron_num;
    w_pkt_done_nxt     = 1'b0;
    w_err_nxt          = r_err;

    case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          // Config numbers are published at the header so they are stable
          // before the first payload valid of the packet.
          w_layer_num_nxt  = {26'd0, w_hdr_layer};
          w_neuron_num_nxt = {24'd0, w_hdr_neuron};
          if (w_hdr_bad_layer) begin
            w_err_nxt = 1'b1;
            if (w_hdr_discard_len == 16'd0) begin
              w_pkt_done_nxt = 1'b1;
            end else begin
              w_remaining_nxt = w_hdr_discard_len;
              w_state_nxt     = ST_DISCARD;
            end
          end else if (w_hdr_is_bias) begin
            w_state_nxt = ST_BIAS;
          end else if (w_hdr_count == 16'd0) begin
            w_pkt_done_nxt = 1'b1;
          end else if (w_hdr_oversize) begin
            w_err_nxt       = 1'b1;
            w_remaining_nxt = w_hdr_count;
            w_state_nxt     = ST_DISCARD;
          end else begin
            w_remaining_nxt = w_hdr_count;
            w_state_nxt     = ST_WEIGHTS;
          end
        end
      end

      ST_WEIGHTS: begin
        if (w_beat) begin
          w_weight_valid_nxt = 1'b1;
          w_weight_value_nxt = s_data;
          w_remaining_nxt    = r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
            w_pkt_done_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
          end
        end
      end

      ST_BIAS: begin
        if (w_beat) begin
          w_bias_valid_nxt = 1'b1;
          w_bias_value_nxt = s_data;
          w_pkt_done_nxt   = 1'b1;
          w_state_nxt      = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        if (w_beat) begin
          w_remaining_nxt = r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
            w_pkt_done_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_remaining_nxt = 16'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_remaining    <= 16'd0;
      r_weight_valid <= 1'b0;
      r_bias_valid   <= 1'b0;
      r_weight_value <= 32'd0;
      r_bias_value   <= 32'd0;
      r_layer_num    <= 32'd0;
      r_neuron_num   <= 32'd0;
      r_pkt_done     <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_remaining    <= w_remaining_nxt;
      r_weight_valid <= w_weight_valid_nxt;
      r_bias_valid   <= w_bias_valid_nxt;
      r_weight_value <= w_weight_value_nxt;
      r_bias_value   <= w_bias_value_nxt;
      r_layer_num    <= w_layer_num_nxt;
      r_neuron_num   <= w_neuron_num_nxt;
      r_pkt_done     <= w_pkt_done_nxt;
      r_err          <= w_err_nxt;
    end
  end

  assign weight_valid      = r_weight_valid;
  assign bias_valid        = r_bias_valid;
  assign weight_value      = r_weight_value;
  assign bias_value        = r_bias_value;
  assign config_layer_num  = r_layer_num;
  assign config_neuron_num = r_neuron_num;
  assign pkt_done          = r_pkt_done;
  assign err               = r_err;
  assign busy              = (r_state != ST_IDLE);

endmodule
